// File: rtl/ureg_pkg.sv
// Shared types for the universal datapath register.
package ureg_pkg;

    // Operation applied on a write-enabled edge
    typedef enum logic [2:0] {
        UR_HOLD = 3'd0,
        UR_LOAD = 3'd1,
        UR_SHL  = 3'd2,
        UR_SHR  = 3'd3,
        UR_ROL  = 3'd4,
        UR_ROR  = 3'd5,
        UR_INC  = 3'd6,
        UR_DEC  = 3'd7
    } ureg_mode_e;

endpackage

// File: rtl/ureg_bit_cell.sv
// One storage bit: synchronous reset to a per-bit value, then enabled load.
module ureg_bit_cell (
    output logic q,
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic d
);

    // Reset has priority over the enable
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_reg.sv
// General datapath register: hold, load, shift, rotate, increment, decrement.
module universal_reg
    import ureg_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  ureg_mode_e       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt;

    // WIDTH+1-bit unsigned add/subtract; the MSB is carry (INC) or borrow (DEC)
    always_comb begin
        sum = SW'(q);
        if (mode == UR_INC) begin
            sum = SW'(q) + SW'(1);
        end else if (mode == UR_DEC) begin
            sum = SW'(q) - SW'(1);
        end
    end

    // Next-state mux; HOLD feeds the current state back
    always_comb begin
        q_nxt     = q;
        carry_nxt = carry;
        case (mode)
            UR_HOLD: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
            UR_LOAD: begin
                q_nxt     = d;
                carry_nxt = 1'b0;
            end
            UR_SHL: begin
                q_nxt     = {q[WIDTH-2:0], sin};
                carry_nxt = q[WIDTH-1];
            end
            UR_SHR: begin
                q_nxt     = {sin, q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            UR_ROL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_nxt = q[WIDTH-1];
            end
            UR_ROR: begin
                q_nxt     = {q[0], q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            UR_INC, UR_DEC: begin
                q_nxt     = sum[WIDTH-1:0];
                carry_nxt = sum[WIDTH];
            end
        endcase
    end

    // Data bits, each resetting to its own bit of RST_VAL
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        ureg_bit_cell u_cell (
            .q       (q[j]),
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[j]),
            .en      (wr),
            .d       (q_nxt[j])
        );
    end

    // Carry/borrow flag, reset to 0
    ureg_bit_cell u_carry (
        .q       (carry),
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .en      (wr),
        .d       (carry_nxt)
    );

    // Zero flag follows the register contents
    always_comb begin
        zero = (q == '0);
    end

endmodule

// File: tb/tb_universal_reg.sv
// Directed-vector and randomised-model bench for universal_reg.
module tb_universal_reg;
    import ureg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, wr, sin;
    ureg_mode_e mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       carry, zero;

    logic       rst4, wr4, sin4;
    ureg_mode_e mode4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic       carry4, zero4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    universal_reg #(.WIDTH(8), .RST_VAL(8'hFF)) dut (
        .clk(clk), .rst(rst), .wr(wr), .mode(mode), .d(d), .sin(sin),
        .q(q), .carry(carry), .zero(zero)
    );

    universal_reg #(.WIDTH(4), .RST_VAL(4'h5)) dut4 (
        .clk(clk), .rst(rst4), .wr(wr4), .mode(mode4), .d(d4), .sin(sin4),
        .q(q4), .carry(carry4), .zero(zero4)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        ureg_mode_e mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       ec;
        logic       ez;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic r, logic w, ureg_mode_e m, logic [7:0] dd,
                                logic s, logic [7:0] eq, logic ec, logic ez);
        vec_t v;
        v.rst = r; v.wr = w; v.mode = m; v.d = dd; v.sin = s;
        v.eq = eq; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge, then sample well after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: returns {carry, q}
    function automatic logic [8:0] model(logic [7:0] mq, logic mc, logic r, logic w,
                                         ureg_mode_e m, logic [7:0] dd, logic s);
        logic [7:0] nq;
        logic       nc;
        nq = mq;
        nc = mc;
        if (r) begin
            nq = 8'hFF;
            nc = 1'b0;
        end else if (w) begin
            if (m == UR_LOAD) begin nq = dd; nc = 1'b0; end
            if (m == UR_SHL)  begin nq = (mq << 1) | {7'd0, s}; nc = mq[7]; end
            if (m == UR_SHR)  begin nq = (mq >> 1) | {s, 7'd0}; nc = mq[0]; end
            if (m == UR_ROL)  begin nq = (mq << 1) | (mq >> 7); nc = mq[7]; end
            if (m == UR_ROR)  begin nq = (mq >> 1) | (mq << 7); nc = mq[0]; end
            if (m == UR_INC)  begin nq = mq + 8'd1; nc = (mq == 8'hFF); end
            if (m == UR_DEC)  begin nq = mq - 8'd1; nc = (mq == 8'h00); end
        end
        return {nc, nq};
    endfunction

    initial begin
        logic [7:0] mq;
        logic       mc;
        logic [8:0] nx;

        rst = 1'b0; wr = 1'b0; mode = UR_HOLD; d = '0; sin = 1'b0;
        rst4 = 1'b0; wr4 = 1'b0; mode4 = UR_HOLD; d4 = '0; sin4 = 1'b0;

        //              rst   wr    mode     d      sin   q      c     z
        vecs[0]  = mk(1'b1, 1'b0, UR_HOLD, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, UR_LOAD, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, UR_LOAD, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, UR_LOAD, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, UR_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, UR_SHL,  8'h00, 1'b1, 8'h4B, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, UR_SHR,  8'h00, 1'b0, 8'h25, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, UR_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, UR_ROL,  8'h00, 1'b0, 8'h03, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, UR_ROR,  8'h00, 1'b0, 8'h81, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, UR_ROR,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b1, UR_LOAD, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, UR_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, UR_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, UR_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, UR_DEC,  8'h00, 1'b0, 8'hFE, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, UR_HOLD, 8'h77, 1'b1, 8'hFE, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, UR_LOAD, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
        vecs[18] = mk(1'b1, 1'b1, UR_INC,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);

        #2;
        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; wr = vecs[i].wr; mode = vecs[i].mode;
            d = vecs[i].d; sin = vecs[i].sin;
            tick();
            chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
            chk($sformatf("vec%0d_carry", i), 8'(carry), 8'(vecs[i].ec));
            chk($sformatf("vec%0d_zero", i), 8'(zero), 8'(vecs[i].ez));
        end

        // Shift-out of a zero MSB clears a previously set carry
        rst = 1'b0; wr = 1'b1; mode = UR_LOAD; d = 8'hFF; tick();
        mode = UR_INC; tick();
        chk("seq_inc_wrap_carry", 8'(carry), 8'd1);
        mode = UR_SHL; sin = 1'b0; tick();
        chk("seq_shl_zero_q", q, 8'h00);
        chk("seq_shl_zero_carry", 8'(carry), 8'd0);
        chk("seq_shl_zero_flag", 8'(zero), 8'd1);

        // Randomised run against the reference model
        rst = 1'b1; wr = 1'b0; tick();
        mq = 8'hFF; mc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 15) == 0);
            wr   = ($urandom_range(0, 3) != 0);
            mode = ureg_mode_e'($urandom_range(0, 7));
            d    = 8'($urandom);
            sin  = 1'($urandom);
            nx = model(mq, mc, rst, wr, mode, d, sin);
            mc = nx[8];
            mq = nx[7:0];
            tick();
            if (q !== mq || carry !== mc || zero !== (mq == 8'h00)) begin
                chk("rand_q", q, mq);
                chk("rand_carry", 8'(carry), 8'(mc));
                chk("rand_zero", 8'(zero), 8'(mq == 8'h00));
            end else begin
                checks++;
            end
        end

        // Narrow instance with a non-trivial reset value
        rst4 = 1'b1; tick();
        chk("w4_reset_q", 8'(q4), 8'h05);
        chk("w4_reset_carry", 8'(carry4), 8'd0);
        chk("w4_reset_zero", 8'(zero4), 8'd0);
        rst4 = 1'b0; wr4 = 1'b1; mode4 = UR_LOAD; d4 = 4'hF; tick();
        chk("w4_load_q", 8'(q4), 8'h0F);
        mode4 = UR_INC; tick();
        chk("w4_inc_wrap_q", 8'(q4), 8'h00);
        chk("w4_inc_wrap_carry", 8'(carry4), 8'd1);
        chk("w4_inc_wrap_zero", 8'(zero4), 8'd1);
        mode4 = UR_DEC; tick();
        chk("w4_dec_wrap_q", 8'(q4), 8'h0F);
        chk("w4_dec_wrap_carry", 8'(carry4), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
